tff_count_sequencer: RTL and testbench
======================================

// Module: tff_count_sequencer
// PURPOSE
//  Sequences a WIDTH-bit bank of toggle flip-flops as a programmable modulo-N up/down counter.
//  Each counter step computes the per-bit toggle enables (t_vec), which the internal T-register bank applies.
//  A start/pause/resume/clear FSM controls the count.
//  Sits between control logic and any consumer of a tick-divided count or terminal-count pulse.
// PARAMETERS
//  WIDTH     4  counter/toggle-bank width in bits
//  PRESCALE  1  clocks per count step while running; must be >=1
//               (prescaler counter width = $clog2(PRESCALE)+1)
// PORTS
//  clk      in   1      rising-edge clock
//  rst_n    in   1      asynchronous active-low reset
//  clr      in   1      sync clear; highest priority below reset
//  start    in   1      start (IDLE/DONE) or resume (HOLD)
//  stop     in   1      pause request (RUN only)
//  up_dn    in   1      1=count up, 0=count down; sampled on start from IDLE/DONE
//  mod_val  in   WIDTH  modulus N; sampled on start from IDLE/DONE; 0 means 2^WIDTH
//  count    out  WIDTH  T-bank state (q of each toggle bit)
//  t_vec    out  WIDTH  toggle enables applied at the next edge, combinational:
//                       count ^ count_next on a step, else 0
//  tc       out  1      registered 1-cycle pulse after the terminal step
//  busy     out  1      1 in RUN or HOLD
//  done     out  1      1 in DONE
// BEHAVIOUR
//  Reset values: state=IDLE, count=0, prescaler=0, latched mod/dir=0, tc=0, busy=0, done=0.
//  States are IDLE=2'b00, RUN=2'b01, HOLD=2'b10, DONE=2'b11.
//  step = (state==RUN) && !stop && !clr && (prescaler==PRESCALE-1).
//    The prescaler increments in RUN and wraps to 0 on step.
//    The prescaler is frozen in HOLD and zeroed on entry to RUN from IDLE/DONE.
//  IDLE: start -> RUN.
//    Latch N=mod_val and dir=up_dn.
//    count <= 0 if up; count <= N-1 if down.
//  RUN:
//    stop -> HOLD. Any coincident step is suppressed.
//    On step, up: count <= (count==N-1) ? 0 : count+1.
//    On step, down: count <= (count==0) ? N-1 : count-1.
//    The terminal step (up from N-1, down from 0) asserts tc on the next cycle.
//      Without the macro: state -> DONE, and count keeps the wrapped value.
//  HOLD: start -> RUN. count and prescaler are kept, so no step is lost or repeated.
//  DONE: done=1, count held. start -> same as from IDLE (fresh latch).
//  start in RUN, and stop in IDLE/HOLD/DONE, are ignored.
//  start and stop together in HOLD: stop wins and the FSM stays in HOLD.
//  clr (any state): state=IDLE, count=0, prescaler=0, tc=0. It overrides start/stop/step.
//  Async reset mid-run returns to the reset values immediately, with no tc.
//  Arithmetic is modulo 2^WIDTH; N=0 runs the full range 0..2^WIDTH-1.
//  N=1: count stays 0, t_vec=0, and every step is terminal.
//  Latency: count changes on the edge ending the step cycle. tc follows one cycle after that edge.
//  mod_val/up_dn changes during RUN/HOLD have no effect until the next start from IDLE/DONE.
// CONFIGURATION
//  TFF_AUTO_RELOAD_EN defined: the terminal step stays in RUN (free-running wrap).
//    tc pulses on every wrap and DONE is never entered.
//  TFF_AUTO_RELOAD_EN undefined: one-shot behaviour; the terminal step moves to DONE as described above.
// TESTING
//  1. Reset sequence:
//     rst_n low while running -> count=0, state IDLE, tc/busy/done=0 in the same cycle.
//  2. WIDTH=4, PRESCALE=1, N=10, up, start (macro off):
//     count 0..9, t_vec at 7->8 = 4'b1111, 9->0 wrap.
//     tc high exactly 1 cycle, then done=1, count=0.
//  3. Down, N=5, PRESCALE=3:
//     count 4,3,2,1,0,4 with a step every 3rd clock.
//     tc follows 0->4, total 15 clocks from start to tc.
//  4. Pause/resume:
//     stop at count=6 -> HOLD, busy=1, count frozen for 20 clocks.
//     start -> next step 6->7 after the remaining prescale.
//     stop+start in the same HOLD cycle -> still HOLD.
//  5. Boundary moduli:
//     N=0 up counts 0..15 then wraps.
//     N=1 gives count=0, t_vec=0, and tc after the first step.
//     clr mid-RUN -> IDLE, count=0, no tc.
//  6. TFF_AUTO_RELOAD_EN defined, N=3 up, 12 steps:
//     tc pulses 4 times, done never asserts, busy stays 1.

Source files
------------

// File: rtl/tff_count_sequencer.sv
// Programmable modulo-N up/down counter built on a T-flip-flop bank, with a start/pause/resume/clear FSM.
// Define TFF_AUTO_RELOAD_EN for free-running wrap; leave it undefined for one-shot operation.
module tff_count_sequencer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             start,
  input  logic             stop,
  input  logic             up_dn,
  input  logic [WIDTH-1:0] mod_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] t_vec,
  output logic             tc,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_dbg
);

  localparam int            PW      = $clog2(PRESCALE) + 1;
  localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic [PW-1:0]    psc_q, psc_d;

  logic [WIDTH-1:0] n_last;
  logic [WIDTH-1:0] count_step;
  logic             step;
  logic             terminal;

  // N=0 makes n_last all ones, so the full 2^WIDTH range falls out of plain wrap arithmetic.
  always_comb begin
    n_last     = mod_q - WIDTH'(1);
    step       = (state_q == RUN) && !stop && !clr && (psc_q == PS_LAST);
    count_step = count_q;
    terminal   = 1'b0;
    if (dir_q) begin
      count_step = (count_q == n_last) ? '0 : count_q + WIDTH'(1);
      terminal   = step && (count_q == n_last);
    end else begin
      count_step = (count_q == '0) ? n_last : count_q - WIDTH'(1);
      terminal   = step && (count_q == '0);
    end
    t_vec = step ? (count_q ^ count_step) : '0;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q ^ t_vec;
    psc_d   = psc_q;
    mod_d   = mod_q;
    dir_d   = dir_q;
    tc_d    = terminal;
    if (clr) begin
      state_d = IDLE;
      count_d = '0;
      psc_d   = '0;
      tc_d    = 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d = RUN;
            mod_d   = mod_val;
            dir_d   = up_dn;
            count_d = up_dn ? '0 : mod_val - WIDTH'(1);
            psc_d   = '0;
          end
        end
        RUN: begin
          // A pause freezes the prescaler so the step in progress resumes where it left off.
          if (stop) begin
            state_d = HOLD;
          end else if (step) begin
            psc_d = '0;
`ifndef TFF_AUTO_RELOAD_EN
            if (terminal) state_d = DONE;
`endif
          end else begin
            psc_d = psc_q + PW'(1);
          end
        end
        HOLD: begin
          if (start && !stop) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      psc_q   <= '0;
      mod_q   <= '0;
      dir_q   <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      psc_q   <= psc_d;
      mod_q   <= mod_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
    end
  end

  assign count     = count_q;
  assign tc        = tc_q;
  assign busy      = (state_q == RUN) || (state_q == HOLD);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: tb/tb_tff_count_sequencer.sv
// Directed bench for tff_count_sequencer: PRESCALE=1 and PRESCALE=3 instances share one stimulus stream.
module tb_tff_count_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       up_dn = 1'b0;
  logic [3:0] mod_val = 4'd0;

  logic [3:0] count1, tvec1, count3, tvec3;
  logic       tc1, busy1, done1, tc3, busy3, done3;
  logic [1:0] st1, st3;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  tff_count_sequencer #(.WIDTH(4), .PRESCALE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .stop(stop), .up_dn(up_dn),
    .mod_val(mod_val), .count(count1), .t_vec(tvec1), .tc(tc1), .busy(busy1),
    .done(done1), .state_dbg(st1)
  );

  tff_count_sequencer #(.WIDTH(4), .PRESCALE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start), .stop(stop), .up_dn(up_dn),
    .mod_val(mod_val), .count(count3), .t_vec(tvec3), .tc(tc3), .busy(busy3),
    .done(done3), .state_dbg(st3)
  );

  typedef struct {
    logic       start;
    logic [3:0] mod_val;
    logic       up_dn;
    logic [3:0] count;
    logic [3:0] t_vec;
    logic       tc;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vecs[13];
  logic [3:0] exp3[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 1ns later.
  task automatic drive(input logic s, input logic p, input logic c);
    @(negedge clk);
    start = s;
    stop  = p;
    clr   = c;
    #1;
  endtask

  initial begin
    int tc_cnt;
    logic done_seen;

    vecs[0]  = '{1'b1, 4'd10, 1'b1, 4'd0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'd10, 1'b1, 4'd0, 4'h1, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 4'd10, 1'b1, 4'd1, 4'h3, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 4'd10, 1'b1, 4'd2, 4'h1, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 4'd10, 1'b1, 4'd3, 4'h7, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 4'd10, 1'b1, 4'd4, 4'h1, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 4'd10, 1'b1, 4'd5, 4'h3, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 4'd10, 1'b1, 4'd6, 4'h1, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 4'd10, 1'b1, 4'd7, 4'hF, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 4'd10, 1'b1, 4'd8, 4'h1, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 4'd10, 1'b1, 4'd9, 4'h9, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 4'd10, 1'b1, 4'd0, 4'h0, 1'b1, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 4'd10, 1'b1, 4'd0, 4'h0, 1'b0, 1'b0, 1'b1};
    exp3 = '{4'd4, 4'd4, 4'd4, 4'd3, 4'd3, 4'd3, 4'd2, 4'd2,
             4'd2, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd4};

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", count1, 4'd0);
    chk("rst_state", st1, 2'b00);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_tc", tc1, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef TFF_AUTO_RELOAD_EN
    // N=10 up, PRESCALE=1, one-shot
    drive(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      start   = vecs[i].start;
      mod_val = vecs[i].mod_val;
      up_dn   = vecs[i].up_dn;
      stop    = 1'b0;
      clr     = 1'b0;
      #1;
      chk($sformatf("tbl%0d_count", i), count1, vecs[i].count);
      chk($sformatf("tbl%0d_tvec", i), tvec1, vecs[i].t_vec);
      chk($sformatf("tbl%0d_tc", i), tc1, vecs[i].tc);
      chk($sformatf("tbl%0d_busy", i), busy1, vecs[i].busy);
      chk($sformatf("tbl%0d_done", i), done1, vecs[i].done);
    end
`endif

    // Down N=5, PRESCALE=3
    drive(1'b0, 1'b0, 1'b1);
    up_dn = 1'b0;
    mod_val = 4'd5;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("dn%0d_count", i), count3, exp3[i]);
      chk($sformatf("dn%0d_tc", i), tc3, (i == 15));
      if (i < 15 && (i % 3) != 2) chk($sformatf("dn%0d_tvec", i), tvec3, 4'h0);
    end
`ifndef TFF_AUTO_RELOAD_EN
    chk("dn_done", done3, 1'b1);
`endif

    // Pause/resume on the PRESCALE=3 instance, up N=10
    drive(1'b0, 1'b0, 1'b1);
    up_dn = 1'b1;
    mod_val = 4'd10;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0);
    chk("pause_count", count3, 4'd6);
    chk("pause_state_run", st3, 2'b01);
    for (int h = 0; h < 20; h++) begin
      if (h == 10) drive(1'b1, 1'b1, 1'b0);
      else drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("hold%0d_count", h), count3, 4'd6);
      chk($sformatf("hold%0d_state", h), st3, 2'b10);
      chk($sformatf("hold%0d_busy", h), busy3, 1'b1);
    end
    drive(1'b1, 1'b0, 1'b0);
    chk("resume_pre_state", st3, 2'b10);
    drive(1'b0, 1'b0, 1'b0);
    chk("resume0_state", st3, 2'b01);
    chk("resume0_count", count3, 4'd6);
    drive(1'b0, 1'b0, 1'b0);
    chk("resume1_count", count3, 4'd6);
    chk("resume1_tvec", tvec3, 4'h1);
    drive(1'b0, 1'b0, 1'b0);
    chk("resume2_count", count3, 4'd7);

    // N=0 runs the full range
    drive(1'b0, 1'b0, 1'b1);
    mod_val = 4'd0;
    up_dn = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("n0_%0d_count", i), count1, i);
    end
    chk("n0_tvec_wrap", tvec1, 4'hF);
    drive(1'b0, 1'b0, 1'b0);
    chk("n0_wrap_count", count1, 4'd0);
    chk("n0_wrap_tc", tc1, 1'b1);

    // N=1: every step is terminal
    drive(1'b0, 1'b0, 1'b1);
    mod_val = 4'd1;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("n1_count", count1, 4'd0);
    chk("n1_tvec", tvec1, 4'h0);
    chk("n1_tc_early", tc1, 1'b0);
    chk("n1_busy", busy1, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    chk("n1_count_after", count1, 4'd0);
    chk("n1_tc", tc1, 1'b1);
`ifndef TFF_AUTO_RELOAD_EN
    chk("n1_done", done1, 1'b1);
`endif

    // clr mid-RUN
    drive(1'b0, 1'b0, 1'b1);
    mod_val = 4'd10;
    drive(1'b1, 1'b0, 1'b0);
    repeat (3) drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    chk("clr_pre_count", count1, 4'd3);
    chk("clr_tvec", tvec1, 4'h0);
    drive(1'b0, 1'b0, 1'b0);
    chk("clr_count", count1, 4'd0);
    chk("clr_state", st1, 2'b00);
    chk("clr_busy", busy1, 1'b0);
    chk("clr_tc", tc1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("clr_tc_later", tc1, 1'b0);

    // Async reset while a terminal step is pending
    mod_val = 4'd2;
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("arst_pre_count", count1, 4'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_count", count1, 4'd0);
    chk("arst_state", st1, 2'b00);
    chk("arst_busy", busy1, 1'b0);
    chk("arst_done", done1, 1'b0);
    chk("arst_tc", tc1, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    chk("arst_tc_later", tc1, 1'b0);
    rst_n = 1'b1;

`ifdef TFF_AUTO_RELOAD_EN
    // Auto-reload: N=3 up, 12 steps
    drive(1'b0, 1'b0, 1'b1);
    mod_val = 4'd3;
    up_dn = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    tc_cnt = 0;
    done_seen = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      drive(1'b0, 1'b0, 1'b0);
      chk($sformatf("ar%0d_count", i), count1, i % 3);
      chk($sformatf("ar%0d_busy", i), busy1, 1'b1);
      if (tc1 === 1'b1) tc_cnt++;
      if (done1 !== 1'b0) done_seen = 1'b1;
    end
    chk("ar_tc_pulses", tc_cnt, 4);
    chk("ar_done_seen", done_seen, 1'b0);
`else
    tc_cnt = 0;
    done_seen = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
